riscv_single_cycle: RTL and testbench
=====================================

# riscv_single_cycle

Single-cycle RV32I-subset processor core with no external ports beyond clock and reset. Each rising clock edge completes one instruction: fetch, decode, execute, memory access, and write-back. Instruction memory, register file, and data memory are internal to a datapath instance named `dp`. Benches load programs and inspect results hierarchically through that instance.

## Interface
- `IMEM_DEPTH`, default 64: instruction memory depth in 32-bit words.
- `DMEM_DEPTH`, default 64: data memory depth in 32-bit words.
- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `rst` input, 1 bit: one clock; reset is asynchronous and active-high.
- No other ports.
- Fixed hierarchical names:
  - `dp.instr_mem[0:IMEM_DEPTH-1]`: 32-bit words, writable by the bench.
  - `dp.regfile[0:31]`: 32-bit registers.
  - `dp.dmem[0:DMEM_DEPTH-1]`: 32-bit words.

## Operation
- Fetch:
  - Instruction is `dp.instr_mem[(pc>>2) mod IMEM_DEPTH]`.
  - PC is 32 bits, word-aligned.
  - Default next PC is pc+4.
  - Fetch index wraps modulo IMEM_DEPTH.
- Supported instructions:
  - R-type: add, sub, and, or, xor, slt, sll, srl. Shift amount is rs2[4:0].
  - I-type ALU: addi, andi, ori, xori, slti. Immediate is 12-bit, sign-extended.
  - lw: rd = dmem[((rs1+imm)>>2) mod DMEM_DEPTH]. The low 2 address bits are ignored.
  - sw: dmem[same index] = rs2. S-type immediate, sign-extended.
- Arithmetic: 32-bit two's complement, wrap on overflow, no traps. slt and slti compare signed.
- Register file:
  - Two combinational read ports, one write port.
  - x0 reads as 0 at all times; writes to x0 are discarded.
  - An instruction that reads and writes the same register sees the old value.
- Unsupported opcodes (including 32'h00000000): no register write, no memory write, PC+4.
- Memory initial contents:
  - instr_mem and dmem are initialised to all zeros at time 0.
  - Neither is cleared by `rst`.
  - The bench may write instr_mem while `rst` is asserted or between clock edges.

## Timing
- Reset (asynchronous, immediate on `rst`=1):
  - pc = 0.
  - All 32 registers = 0.
  - dmem and instr_mem unchanged.
  - Any in-flight write for the current cycle is discarded.
- While `rst`=1: no register writes, no memory writes, PC held at 0.
- First rising edge after `rst` falls: executes instr_mem[0].
- Latency:
  - One instruction per cycle.
  - Results are visible in regfile/dmem immediately after the executing edge.
  - A following instruction uses the result with no stall (no pipeline, no hazards).
- Reads:
  - lw reads dmem combinationally in the same cycle; rd is written at the edge.
  - A sw followed by lw to the same address in the next cycle returns the stored value.
- Instruction-memory reads are combinational on pc.

## Configuration
- Macro `RISCV_BRANCH_EN`.
- Defined:
  - Adds beq, bne, and jal.
  - Branch target is pc + sign-extended B-immediate when taken; jal target is pc + J-immediate.
  - jal writes pc+4 to rd (discarded if rd=x0).
  - Bit 0 of every target is forced to 0.
- Undefined: opcodes 1100011 and 1101111 decode as unsupported (PC+4, no side effects).

## Test plan
- Basic program, each result checked after its executing edge:
  - Stimulus: assert `rst` 10 ns, deassert, then load instr_mem[0..5] = 00500093, 00a00113, 002081b3, 00302023, 00002283, 00000013. Run 10 cycles.
  - Required: x1=5, x2=10, x3=15, dmem[0]=15, x5=15.
- Corner cases:
  - `addi x0,x0,7` → x0 stays 0.
  - `addi x1,x0,-1` (fff00093) → x1=32'hFFFFFFFF.
  - Then `slt x2,x1,x0` → x2=1.
  - Then `sub x3,x0,x1` → x3=1.
- Reset mid-run: assert `rst` between edges after the 3rd instruction → pc=0 and x1..x31=0 immediately. dmem keeps stored values. After release, the program restarts at instr_mem[0].
- Wrap: PC runs past IMEM_DEPTH words of zeros → no register or memory changes, PC wraps and re-executes instr_mem[0].
- With `RISCV_BRANCH_EN`:
  - `beq x0,x0,+8` skips the next instruction.
  - `jal x1,+8` at pc=16 → x1=20, next pc=24.
  - Without the macro, both execute as no-ops.

Source files
------------

// File: rtl/riscv_single_cycle.sv
// riscv_single_cycle: single-cycle RV32I-subset core (add/sub/and/or/xor/slt/sll/srl, addi/andi/ori/xori/slti, lw, sw).
// Latency: one instruction retires per rising clk edge; results are visible in regfile/dmem right after that edge.
// Backpressure: none; the core has no external handshake and never stalls.
// Ports: clk (single clock, rising edge), rst (asynchronous, active-high; clears pc and regfile, leaves memories alone).
// Optional feature: define RISCV_BRANCH_EN to add beq, bne and jal. Without it those opcodes retire as no-ops.
// Hierarchy: instruction memory, register file and data memory live in the datapath instance dp
//            (dp.instr_mem, dp.regfile, dp.dmem) so programs can be loaded and results inspected there.

module riscv_datapath #(
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 64
) (
  input logic clk,
  input logic rst
);
  localparam int IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
`ifdef RISCV_BRANCH_EN
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
`endif

  // Memories start at zero and are never touched by rst; instr_mem is only
  // ever written from outside (program loading).
  logic [31:0] instr_mem [0:IMEM_DEPTH-1] = '{default: 32'h0};
  logic [31:0] dmem      [0:DMEM_DEPTH-1] = '{default: 32'h0};
  logic [31:0] regfile   [0:31];
  logic [31:0] pc;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] rs1_val, rs2_val, imm_i, imm_s, addr, load_val;
  logic        rf_we, mem_we;
  logic [31:0] rf_wd, next_pc;

  // Fetch index wraps modulo the memory depth; pc itself keeps counting.
  assign instr  = instr_mem[IAW'((pc >> 2) % IMEM_DEPTH)];
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign rs1_val = (rs1 == 5'd0) ? 32'h0 : regfile[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'h0 : regfile[rs2];
  assign imm_i   = {{20{instr[31]}}, instr[31:20]};
  assign imm_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};

  // Shared address adder for lw/sw; the low two address bits are dropped.
  assign addr     = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign load_val = dmem[DAW'((addr >> 2) % DMEM_DEPTH)];

`ifdef RISCV_BRANCH_EN
  logic [31:0] imm_b, imm_j;
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
`endif

  always_comb begin
    rf_we   = 1'b0;
    rf_wd   = 32'h0;
    mem_we  = 1'b0;
    next_pc = pc + 32'd4;
    case (opcode)
      OP_R: begin
        rf_we = 1'b1;
        case (funct3)
          3'b000: begin
            if (funct7 == 7'b0000000)      rf_wd = rs1_val + rs2_val;
            else if (funct7 == 7'b0100000) rf_wd = rs1_val - rs2_val;
            else                           rf_we = 1'b0;
          end
          3'b111:  rf_wd = rs1_val & rs2_val;
          3'b110:  rf_wd = rs1_val | rs2_val;
          3'b100:  rf_wd = rs1_val ^ rs2_val;
          3'b010:  rf_wd = {31'h0, $signed(rs1_val) < $signed(rs2_val)};
          3'b001:  rf_wd = rs1_val << rs2_val[4:0];
          3'b101: begin
            if (funct7 == 7'b0000000) rf_wd = rs1_val >> rs2_val[4:0];
            else                      rf_we = 1'b0;
          end
          default: rf_we = 1'b0;
        endcase
        // Funct7 is only meaningful for add/sub/srl here; other R ops require zero.
        if (funct7 != 7'b0000000 && !(funct3 == 3'b000 && funct7 == 7'b0100000))
          rf_we = 1'b0;
      end
      OP_I: begin
        rf_we = 1'b1;
        case (funct3)
          3'b000:  rf_wd = rs1_val + imm_i;
          3'b111:  rf_wd = rs1_val & imm_i;
          3'b110:  rf_wd = rs1_val | imm_i;
          3'b100:  rf_wd = rs1_val ^ imm_i;
          3'b010:  rf_wd = {31'h0, $signed(rs1_val) < $signed(imm_i)};
          default: rf_we = 1'b0;
        endcase
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          rf_we = 1'b1;
          rf_wd = load_val;
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b010) mem_we = 1'b1;
      end
`ifdef RISCV_BRANCH_EN
      OP_BRANCH: begin
        if ((funct3 == 3'b000 && rs1_val == rs2_val) ||
            (funct3 == 3'b001 && rs1_val != rs2_val))
          next_pc = (pc + imm_b) & ~32'h1;
      end
      OP_JAL: begin
        rf_we   = 1'b1;
        rf_wd   = pc + 32'd4;
        next_pc = (pc + imm_j) & ~32'h1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= 32'h0;
      for (int i = 0; i < 32; i++) regfile[i] <= 32'h0;
    end else begin
      pc <= next_pc;
      if (rf_we && rd != 5'd0) regfile[rd] <= rf_wd;
    end
  end

  // Data memory has no reset; writes are simply suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) dmem[DAW'((addr >> 2) % DMEM_DEPTH)] <= rs2_val;
  end
endmodule

module riscv_single_cycle #(
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 64
) (
  input logic clk,
  input logic rst
);
  riscv_datapath #(
    .IMEM_DEPTH(IMEM_DEPTH),
    .DMEM_DEPTH(DMEM_DEPTH)
  ) dp (
    .clk(clk),
    .rst(rst)
  );
endmodule

// File: tb/tb_riscv_single_cycle.sv
// tb_riscv_single_cycle: directed programs for riscv_single_cycle with table-driven result checks.
// Each program is loaded under reset; table rows name the edge count after which a register,
// dmem word or pc must hold a hand-computed value. Mid-run reset and fetch wrap are hand sequences.

module tb_riscv_single_cycle;
  localparam int IMEM_DEPTH = 64;
  localparam int DMEM_DEPTH = 64;
  localparam int K_REG = 0;
  localparam int K_MEM = 1;
  localparam int K_PC  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  riscv_single_cycle #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)) dut (
    .clk(clk),
    .rst(rst)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          kind;
    int          idx;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] prog[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] peek(input int kind, input int idx);
    case (kind)
      K_REG:   return dut.dp.regfile[idx];
      K_MEM:   return dut.dp.dmem[idx];
      default: return dut.dp.pc;
    endcase
  endfunction

  function automatic int nonzero_regs(input int skip);
    int n = 0;
    for (int i = 1; i < 32; i++)
      if (i != skip && dut.dp.regfile[i] !== 32'h0) n++;
    return n;
  endfunction

  function automatic int nonzero_dmem();
    int n = 0;
    for (int i = 0; i < DMEM_DEPTH; i++)
      if (dut.dp.dmem[i] !== 32'h0) n++;
    return n;
  endfunction

  task automatic add(input int c, input int k, input int i, input logic [31:0] e, input string n);
    vec_t v;
    v.cyc = c; v.kind = k; v.idx = i; v.exp = e; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Hold reset, wipe both memories, load prog, release between edges.
  task automatic restart();
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < IMEM_DEPTH; i++) dut.dp.instr_mem[i] = 32'h0;
    for (int i = 0; i < DMEM_DEPTH; i++) dut.dp.dmem[i] = 32'h0;
    for (int i = 0; i < prog.size(); i++) dut.dp.instr_mem[i] = prog[i];
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic run_table();
    for (int i = 0; i < vecs.size(); i++) begin
      while (cyc < vecs[i].cyc) tick();
      check(vecs[i].name, peek(vecs[i].kind, vecs[i].idx), vecs[i].exp);
    end
    vecs.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state while rst is held from time 0.
    #3;
    check("reset_pc", dut.dp.pc, 32'h0);
    check("reset_regs_nonzero", 32'(nonzero_regs(0)), 32'h0);

    // Basic program.
    prog = '{32'h00500093, 32'h00a00113, 32'h002081b3, 32'h00302023, 32'h00002283, 32'h00000013};
    restart();
    add(1,  K_REG, 1, 32'd5,  "basic_x1");
    add(2,  K_REG, 2, 32'd10, "basic_x2");
    add(3,  K_REG, 3, 32'd15, "basic_x3");
    add(4,  K_MEM, 0, 32'd15, "basic_dmem0");
    add(5,  K_REG, 5, 32'd15, "basic_x5_lw");
    add(5,  K_PC,  0, 32'd20, "basic_pc5");
    add(10, K_PC,  0, 32'd40, "basic_pc10");
    add(10, K_REG, 1, 32'd5,  "basic_x1_held");
    add(10, K_MEM, 0, 32'd15, "basic_dmem0_held");
    run_table();

    // Arithmetic corners: x0 write, -1, signed slt, sub, shifts, xori, same-reg read/write.
    prog = '{32'h00700013, 32'hfff00093, 32'h0000a133, 32'h401001b3,
             32'h00309233, 32'h0030d2b3, 32'h0f00c313, 32'h00108093};
    restart();
    add(1, K_REG, 0, 32'h0,        "x0_stays_zero");
    add(2, K_REG, 1, 32'hffffffff, "addi_neg1");
    add(3, K_REG, 2, 32'h1,        "slt_signed");
    add(4, K_REG, 3, 32'h1,        "sub_0_minus_neg1");
    add(5, K_REG, 4, 32'hfffffffe, "sll");
    add(6, K_REG, 5, 32'h7fffffff, "srl_logical");
    add(7, K_REG, 6, 32'hffffff0f, "xori");
    add(8, K_REG, 1, 32'h0,        "addi_same_reg");
    run_table();

    // Reset between edges after the 3rd instruction.
    prog = '{32'h00500093, 32'h00a00113, 32'h002081b3, 32'h00302023, 32'h00002283, 32'h00000013};
    restart();
    dut.dp.dmem[7] = 32'hcafef00d;
    repeat (3) tick();
    check("midrun_x3_before", dut.dp.regfile[3], 32'd15);
    rst = 1'b1;
    #1;
    check("midrun_pc_cleared", dut.dp.pc, 32'h0);
    check("midrun_regs_nonzero", 32'(nonzero_regs(0)), 32'h0);
    check("midrun_dmem_kept", dut.dp.dmem[7], 32'hcafef00d);
    #1;
    rst = 1'b0;
    cyc = 0;
    tick();
    check("restart_x1", dut.dp.regfile[1], 32'd5);
    check("restart_x2_pending", dut.dp.regfile[2], 32'h0);
    check("restart_pc", dut.dp.pc, 32'd4);

    // Fetch wrap: one increment then IMEM_DEPTH-1 words of zeros.
    prog = '{32'h00108093};
    restart();
    repeat (IMEM_DEPTH) tick();
    check("wrap_x1_once", dut.dp.regfile[1], 32'd1);
    check("wrap_other_regs", 32'(nonzero_regs(1)), 32'h0);
    check("wrap_dmem_clean", 32'(nonzero_dmem()), 32'h0);
    tick();
    check("wrap_x1_reexec", dut.dp.regfile[1], 32'd2);

    // beq / jal program; its expectations depend on whether branches are built in.
    prog = '{32'h00000463, 32'h00500093, 32'h00a00113, 32'h00000013,
             32'h008000ef, 32'h00f00193, 32'h00100213};
    restart();
`ifdef RISCV_BRANCH_EN
    add(1, K_PC,  0, 32'd8,  "beq_taken_pc");
    add(1, K_REG, 1, 32'h0,  "beq_skip_x1");
    add(2, K_REG, 2, 32'd10, "beq_target_x2");
    add(4, K_REG, 1, 32'd20, "jal_link_x1");
    add(4, K_PC,  0, 32'd24, "jal_target_pc");
    add(5, K_REG, 4, 32'd1,  "jal_landing_x4");
    add(5, K_REG, 3, 32'h0,  "jal_skip_x3");
`else
    add(1, K_PC,  0, 32'd4,  "beq_noop_pc");
    add(2, K_REG, 1, 32'd5,  "beq_noop_x1");
    add(3, K_REG, 2, 32'd10, "after_beq_x2");
    add(5, K_PC,  0, 32'd20, "jal_noop_pc");
    add(5, K_REG, 1, 32'd5,  "jal_noop_x1");
    add(6, K_REG, 3, 32'd15, "after_jal_x3");
    add(7, K_REG, 4, 32'd1,  "after_jal_x4");
`endif
    run_table();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
